reduce_accumulator: RTL
=======================

REDUCE_ACCUMULATOR -- requirements
Module: reduce_accumulator

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, width of values, sums and the BRAM data.
REQ-002 SHALL have parameter C_LOG_DEPTH, default 2, key width; number of keys DEPTH = 2^C_LOG_DEPTH.
REQ-003 SHALL have port i_clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  in  1  an input (key, value) beat is present.
REQ-006 SHALL have port o_ready  out  1  the block can accept a beat.
REQ-007 SHALL have port i_key  in  C_LOG_DEPTH  key of the beat.
REQ-008 SHALL have port i_value  in  C_WIDTH  value to add to the key's sum.
REQ-009 SHALL have port i_flush  in  1  request to drain all sums.
REQ-010 SHALL have port o_valid  out  1  a drained (key, sum) pair is present.
REQ-011 SHALL have port i_ready  in  1  downstream accepts the pair.
REQ-012 SHALL have port o_key  out  C_LOG_DEPTH  key of the drained pair.
REQ-013 SHALL have port o_sum  out  C_WIDTH  sum of the drained pair.
REQ-014 SHALL have port o_done  out  1  one-cycle pulse after the last pair is accepted.
REQ-015 SHALL have ports o_waddr/o_wen/o_wdata  out  C_LOG_DEPTH/1/C_WIDTH  BRAM write port.
REQ-016 SHALL have ports o_raddr/o_ce  out  C_LOG_DEPTH/1, and i_rdata  in  C_WIDTH  BRAM read port (registered read, 1-cycle latency, read-before-write, o_rdata held while o_ce=0).

Function
REQ-017 SHALL implement FSM states ACCUM, FL_WAIT, FL_RD, FL_OUT; o_ready=1 only in ACCUM.
REQ-018 SHALL, on accept (i_valid & o_ready) in cycle t, drive o_raddr=i_key, o_ce=1 in cycle t and register key/value into stage s1.
REQ-019 SHALL, in cycle t+1 with s1 valid, drive o_wen=1, o_waddr=s1 key, o_wdata=(operand + s1 value) mod 2^C_WIDTH.
REQ-020 SHALL use operand = previous cycle's o_wdata when the previous cycle wrote the same key (forwarding), else i_rdata.
REQ-021 SHALL sustain one accepted beat per cycle with no stall, including back-to-back beats to one key.
REQ-022 SHALL, when i_flush=1 in ACCUM, accept any simultaneous i_valid beat (included in the drain) and go to FL_WAIT.
REQ-023 SHALL spend exactly one cycle in FL_WAIT (pending s1 write completes), clear drain counter cnt to 0, go to FL_RD.
REQ-024 SHALL in FL_RD drive o_raddr=cnt, o_ce=1 for one cycle, then go to FL_OUT.
REQ-025 SHALL in FL_OUT drive o_valid=1, o_key=cnt, o_sum=i_rdata, o_ce=0; hold all stable until i_ready=1.
REQ-026 SHALL on o_valid & i_ready write 0 to address cnt (o_wen=1, o_wdata=0); if cnt=DEPTH-1 pulse o_done next cycle and go to ACCUM, else cnt+1 and go to FL_RD.
REQ-027 SHALL ignore i_flush outside ACCUM and ignore i_valid when o_ready=0.
REQ-028 SHALL drive o_ce=0, o_wen=0 in all cases not listed above.

Reset
REQ-029 SHALL, on i_rst_n=0 at any time including mid-drain, immediately force state ACCUM, s1 invalid, cnt=0, o_valid=0, o_done=0, o_wen=0, o_ce=0, o_key=0, o_sum=0; o_ready=1 after release.
REQ-030 SHALL NOT clear BRAM contents on reset; BRAM initialises to zero at power-up only.

Verification
REQ-031 Reset; beats (1,5),(1,7) back-to-back; flush -> pairs (0,0),(1,12),(2,0),(3,0), o_done one cycle after (3,0) handshake.
REQ-032 Beats (2,1),(2,2),(2,3) consecutive cycles; flush -> key 2 sum 6 (forwarding exercised).
REQ-033 Beats (0,0xFFFFFFFF),(0,2); flush -> key 0 sum 0x00000001 (wrap).
REQ-034 During drain hold i_ready=0 3 cycles at key 1 -> o_valid=1, o_key=1, o_sum stable; no skipped or repeated key.
REQ-035 i_flush with simultaneous beat (3,9) -> key 3 sum 9; second flush immediately after -> all four sums 0.
REQ-036 Assert i_rst_n=0 while o_valid=1 at key 2 -> o_valid=0 without clock edge; after release o_ready=1, next flush drains from key 0.

Source files
------------

// File: rtl/reduce_accumulator_if.sv
// Stream-in / drain-out handshake plus the external BRAM port of reduce_accumulator.
interface reduce_accumulator_if #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_DEPTH = 2
) ();
  logic                   i_valid;
  logic                   o_ready;
  logic [C_LOG_DEPTH-1:0] i_key;
  logic [C_WIDTH-1:0]     i_value;
  logic                   i_flush;
  logic                   o_valid;
  logic                   i_ready;
  logic [C_LOG_DEPTH-1:0] o_key;
  logic [C_WIDTH-1:0]     o_sum;
  logic                   o_done;
  logic [C_LOG_DEPTH-1:0] o_waddr;
  logic                   o_wen;
  logic [C_WIDTH-1:0]     o_wdata;
  logic [C_LOG_DEPTH-1:0] o_raddr;
  logic                   o_ce;
  logic [C_WIDTH-1:0]     i_rdata;

  modport slave (
    input  i_valid, i_key, i_value, i_flush, i_ready, i_rdata,
    output o_ready, o_valid, o_key, o_sum, o_done,
           o_waddr, o_wen, o_wdata, o_raddr, o_ce
  );

  modport master (
    output i_valid, i_key, i_value, i_flush, i_ready, i_rdata,
    input  o_ready, o_valid, o_key, o_sum, o_done,
           o_waddr, o_wen, o_wdata, o_raddr, o_ce
  );
endinterface

// File: rtl/reduce_accumulator.sv
// Per-key running sums held in an external BRAM; one beat per cycle with write forwarding,
// and a flush that drains every (key, sum) pair in key order while zeroing the table.
module reduce_accumulator #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  reduce_accumulator_if.slave bus
);

  localparam int unsigned DEPTH = 1 << C_LOG_DEPTH;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    FL_WAIT = 2'd1,
    FL_RD   = 2'd2,
    FL_OUT  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [C_LOG_DEPTH-1:0] cnt, cnt_nxt;
  logic                   done_q, done_nxt;

  logic                   s1_valid;
  logic [C_LOG_DEPTH-1:0] s1_key;
  logic [C_WIDTH-1:0]     s1_value;

  logic                   prev_wen;
  logic [C_LOG_DEPTH-1:0] prev_waddr;
  logic [C_WIDTH-1:0]     prev_wdata;

  logic                   accept_c;
  logic                   ready_c;
  logic [C_WIDTH-1:0]     operand_c;
  logic                   ce_c, wen_c, valid_c;
  logic [C_LOG_DEPTH-1:0] raddr_c, waddr_c, key_c;
  logic [C_WIDTH-1:0]     wdata_c, sum_c;

  assign accept_c = bus.i_valid & ready_c;

  // BRAM read returns pre-write data, so a same-key write in the previous cycle must be forwarded
  assign operand_c = (prev_wen && (prev_waddr == s1_key)) ? prev_wdata : bus.i_rdata;

  // Next-state and all combinational port drive
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ready_c   = 1'b0;
    ce_c      = 1'b0;
    raddr_c   = '0;
    wen_c     = 1'b0;
    waddr_c   = '0;
    wdata_c   = '0;
    valid_c   = 1'b0;
    key_c     = '0;
    sum_c     = '0;

    if (s1_valid) begin
      wen_c   = 1'b1;
      waddr_c = s1_key;
      wdata_c = operand_c + s1_value;
    end

    unique case (state)
      ACCUM: begin
        ready_c = 1'b1;
        if (bus.i_valid) begin
          ce_c    = 1'b1;
          raddr_c = bus.i_key;
        end
        if (bus.i_flush) state_nxt = FL_WAIT;
      end
      FL_WAIT: begin
        cnt_nxt   = '0;
        state_nxt = FL_RD;
      end
      FL_RD: begin
        ce_c      = 1'b1;
        raddr_c   = cnt;
        state_nxt = FL_OUT;
      end
      FL_OUT: begin
        valid_c = 1'b1;
        key_c   = cnt;
        sum_c   = bus.i_rdata;
        if (bus.i_ready) begin
          wen_c   = 1'b1;
          waddr_c = cnt;
          wdata_c = '0;
          if (cnt == C_LOG_DEPTH'(DEPTH - 1)) begin
            done_nxt  = 1'b1;
            state_nxt = ACCUM;
          end else begin
            cnt_nxt   = cnt + C_LOG_DEPTH'(1);
            state_nxt = FL_RD;
          end
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ACCUM;
      cnt        <= '0;
      done_q     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_key     <= '0;
      s1_value   <= '0;
      prev_wen   <= 1'b0;
      prev_waddr <= '0;
      prev_wdata <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      done_q     <= done_nxt;
      s1_valid   <= accept_c;
      if (accept_c) begin
        s1_key   <= bus.i_key;
        s1_value <= bus.i_value;
      end
      prev_wen   <= wen_c;
      prev_waddr <= waddr_c;
      prev_wdata <= wdata_c;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = valid_c;
  assign bus.o_key   = key_c;
  assign bus.o_sum   = sum_c;
  assign bus.o_done  = done_q;
  assign bus.o_ce    = ce_c;
  assign bus.o_raddr = raddr_c;
  assign bus.o_wen   = wen_c;
  assign bus.o_waddr = waddr_c;
  assign bus.o_wdata = wdata_c;

endmodule
